// File: rtl/apb_req_arbiter_if.sv
// Signal bundle for the two-requester APB master: requester handshakes plus the APB bus.
// "master" is the arbiter's view; "slave" is the view of the requesters and the APB slave.
interface apb_req_arbiter_if;
  logic       req0;
  logic       req1;
  logic       req_write0;
  logic       req_write1;
  logic [8:0] req_addr0;
  logic [8:0] req_addr1;
  logic [7:0] req_wdata0;
  logic [7:0] req_wdata1;
  logic       done0;
  logic       done1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic       err0;
  logic       err1;
  logic       PSEL1;
  logic       PSEL2;
  logic       PENABLE;
  logic       PWRITE;
  logic [8:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic [7:0] PRDATA;

  modport master (
    input  req0, req1, req_write0, req_write1, req_addr0, req_addr1,
           req_wdata0, req_wdata1, PREADY, PSLVERR, PRDATA,
    output done0, done1, rdata0, rdata1, err0, err1,
           PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req0, req1, req_write0, req_write1, req_addr0, req_addr1,
           req_wdata0, req_wdata1, PREADY, PSLVERR, PRDATA,
    input  done0, done1, rdata0, rdata1, err0, err1,
           PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that turns two requester ports into APB transfers, with a
// wait-state timeout that aborts a stalled ACCESS phase.
module apb_req_arbiter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Abort fires on the ACCESS cycle whose count is WAIT_MAX-1, i.e. the WAIT_MAX-th stalled cycle.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       last_gnt;
  logic       last_gnt_nxt;
  logic       gnt;
  logic       gnt_nxt;

  logic       psel1;
  logic       psel1_nxt;
  logic       psel2;
  logic       psel2_nxt;
  logic       penable;
  logic       penable_nxt;
  logic       pwrite;
  logic       pwrite_nxt;
  logic [8:0] paddr;
  logic [8:0] paddr_nxt;
  logic [7:0] pwdata;
  logic [7:0] pwdata_nxt;

  logic       done0;
  logic       done0_nxt;
  logic       done1;
  logic       done1_nxt;
  logic       err0;
  logic       err0_nxt;
  logic       err1;
  logic       err1_nxt;
  logic [7:0] rdata0;
  logic [7:0] rdata0_nxt;
  logic [7:0] rdata1;
  logic [7:0] rdata1_nxt;

  logic       elig0;
  logic       elig1;
  logic       win;
  logic [8:0] win_addr;
  logic       win_write;
  logic [7:0] win_wdata;

  // A requester still showing its done pulse would otherwise be re-granted off its held req.
  assign elig0     = bus.req0 & ~done0;
  assign elig1     = bus.req1 & ~done1;
  assign win       = (elig0 & elig1) ? ~last_gnt : elig1;
  assign win_addr  = win ? bus.req_addr1  : bus.req_addr0;
  assign win_write = win ? bus.req_write1 : bus.req_write0;
  assign win_wdata = win ? bus.req_wdata1 : bus.req_wdata0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      psel1    <= 1'b0;
      psel2    <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= 9'd0;
      pwdata   <= 8'd0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= 8'h00;
      rdata1   <= 8'h00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      last_gnt <= last_gnt_nxt;
      gnt      <= gnt_nxt;
      psel1    <= psel1_nxt;
      psel2    <= psel2_nxt;
      penable  <= penable_nxt;
      pwrite   <= pwrite_nxt;
      paddr    <= paddr_nxt;
      pwdata   <= pwdata_nxt;
      done0    <= done0_nxt;
      done1    <= done1_nxt;
      err0     <= err0_nxt;
      err1     <= err1_nxt;
      rdata0   <= rdata0_nxt;
      rdata1   <= rdata1_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    last_gnt_nxt = last_gnt;
    gnt_nxt      = gnt;
    psel1_nxt    = psel1;
    psel2_nxt    = psel2;
    penable_nxt  = penable;
    pwrite_nxt   = pwrite;
    paddr_nxt    = paddr;
    pwdata_nxt   = pwdata;
    done0_nxt    = 1'b0;
    done1_nxt    = 1'b0;
    err0_nxt     = err0;
    err1_nxt     = err1;
    rdata0_nxt   = rdata0;
    rdata1_nxt   = rdata1;

    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          state_nxt    = SETUP;
          gnt_nxt      = win;
          last_gnt_nxt = win;
          paddr_nxt    = win_addr;
          pwrite_nxt   = win_write;
          pwdata_nxt   = win_wdata;
          psel1_nxt    = ~win_addr[8];
          psel2_nxt    = win_addr[8];
          penable_nxt  = 1'b0;
        end
      end

      SETUP: begin
        state_nxt    = ACCESS;
        penable_nxt  = 1'b1;
        wait_cnt_nxt = 8'd0;
      end

      ACCESS: begin
        if (bus.PREADY || (wait_cnt == WAIT_LAST)) begin
          state_nxt   = IDLE;
          psel1_nxt   = 1'b0;
          psel2_nxt   = 1'b0;
          penable_nxt = 1'b0;
          if (gnt) begin
            done1_nxt = 1'b1;
            err1_nxt  = bus.PREADY ? bus.PSLVERR : 1'b1;
            if (bus.PREADY && !pwrite) begin
              rdata1_nxt = bus.PRDATA;
            end
          end else begin
            done0_nxt = 1'b1;
            err0_nxt  = bus.PREADY ? bus.PSLVERR : 1'b1;
            if (bus.PREADY && !pwrite) begin
              rdata0_nxt = bus.PRDATA;
            end
          end
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        psel1_nxt   = 1'b0;
        psel2_nxt   = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

  assign bus.PSEL1   = psel1;
  assign bus.PSEL2   = psel2;
  assign bus.PENABLE = penable;
  assign bus.PWRITE  = pwrite;
  assign bus.PADDR   = paddr;
  assign bus.PWDATA  = pwdata;
  assign bus.done0   = done0;
  assign bus.done1   = done1;
  assign bus.err0    = err0;
  assign bus.err1    = err1;
  assign bus.rdata0  = rdata0;
  assign bus.rdata1  = rdata1;

  a_psel_onehot: assert property (@(posedge PCLK) !(psel1 && psel2));
  a_penable_access: assert property (@(posedge PCLK) penable |-> (psel1 || psel2));

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a vector table of single transfers plus
// hand-written contention and reset-during-ACCESS sequences.
module tb_apb_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  apb_req_arbiter_if bus();

  apb_req_arbiter #(.WAIT_MAX(4)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic       write;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] waits;
    logic [7:0] prdata;
    logic       slverr;
    logic       exp_psel2;
    logic [3:0] exp_psel_cycles;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0       = 1'b0;
    bus.req1       = 1'b0;
    bus.req_write0 = 1'b0;
    bus.req_write1 = 1'b0;
    bus.req_addr0  = 9'd0;
    bus.req_addr1  = 9'd0;
    bus.req_wdata0 = 8'd0;
    bus.req_wdata1 = 8'd0;
    bus.PREADY     = 1'b0;
    bus.PSLVERR    = 1'b0;
    bus.PRDATA     = 8'd0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_psel1"},   bus.PSEL1, 0);
    check({tag, "_psel2"},   bus.PSEL2, 0);
    check({tag, "_penable"}, bus.PENABLE, 0);
    check({tag, "_pwrite"},  bus.PWRITE, 0);
    check({tag, "_paddr"},   bus.PADDR, 0);
    check({tag, "_pwdata"},  bus.PWDATA, 0);
    check({tag, "_done0"},   bus.done0, 0);
    check({tag, "_done1"},   bus.done1, 0);
    check({tag, "_err0"},    bus.err0, 0);
    check({tag, "_err1"},    bus.err1, 0);
    check({tag, "_rdata0"},  bus.rdata0, 0);
    check({tag, "_rdata1"},  bus.rdata1, 0);
  endtask

  task automatic check_output(input vec_t v, input int psel_n);
    check("vec_done0", bus.done0, !v.id);
    check("vec_done1", bus.done1, v.id);
    check("vec_err", v.id ? bus.err1 : bus.err0, v.exp_err);
    check("vec_rdata", v.id ? bus.rdata1 : bus.rdata0, v.exp_rdata);
    check("vec_psel_cycles", psel_n, v.exp_psel_cycles);
  endtask

  // Drives one transfer from the current negedge and plays the slave until done.
  task automatic apply_stimulus(input vec_t v);
    int   psel_n;
    int   access_n;
    logic got_done;
    psel_n   = 0;
    access_n = 0;
    got_done = 1'b0;
    if (v.id) begin
      bus.req1       = 1'b1;
      bus.req_write1 = v.write;
      bus.req_addr1  = v.addr;
      bus.req_wdata1 = v.wdata;
    end else begin
      bus.req0       = 1'b1;
      bus.req_write0 = v.write;
      bus.req_addr0  = v.addr;
      bus.req_wdata0 = v.wdata;
    end
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        got_done    = 1'b1;
        bus.req0    = 1'b0;
        bus.req1    = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        check_output(v, psel_n);
      end else if (bus.PSEL1 || bus.PSEL2) begin
        psel_n++;
        check("vec_psel1", bus.PSEL1, !v.exp_psel2);
        check("vec_psel2", bus.PSEL2, v.exp_psel2);
        check("vec_penable", bus.PENABLE, psel_n > 1);
        check("vec_paddr", bus.PADDR, v.addr);
        check("vec_pwrite", bus.PWRITE, v.write);
        check("vec_pwdata", bus.PWDATA, v.wdata);
        if (bus.PENABLE) begin
          bus.PREADY  = (access_n == int'(v.waits));
          bus.PRDATA  = v.prdata;
          bus.PSLVERR = v.slverr;
          access_n++;
        end
      end
    end
    check("vec_done_seen", got_done, 1);
    @(negedge clk);
    check("vec_done0_single", bus.done0, 0);
    check("vec_done1_single", bus.done1, 0);
    check("vec_idle_psel", bus.PSEL1 | bus.PSEL2, 0);
    check("vec_err_held", v.id ? bus.err1 : bus.err0, v.exp_err);
  endtask

  task automatic contention();
    int dones;
    int last_c;
    dones  = 0;
    last_c = -1;
    @(negedge clk);
    rst            = 1'b1;
    bus.req0       = 1'b1;
    bus.req_write0 = 1'b0;
    bus.req_addr0  = 9'h011;
    bus.req1       = 1'b1;
    bus.req_write1 = 1'b1;
    bus.req_addr1  = 9'h111;
    bus.req_wdata1 = 8'h6D;
    bus.PREADY     = 1'b1;
    bus.PRDATA     = 8'h42;
    bus.PSLVERR    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40 && dones < 4; c++) begin
      @(negedge clk);
      check("cont_psel_excl", bus.PSEL1 & bus.PSEL2, 0);
      if (bus.PSEL1) check("cont_paddr0", bus.PADDR, 9'h011);
      if (bus.PSEL2) check("cont_paddr1", bus.PADDR, 9'h111);
      if (bus.done0 || bus.done1) begin
        check("cont_order", bus.done1, dones % 2);
        check("cont_one_done", bus.done0 & bus.done1, 0);
        if (last_c >= 0) check("cont_spacing", c - last_c, 3);
        last_c = c;
        dones++;
        if (dones == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
    end
    check("cont_dones", dones, 4);
    @(negedge clk);
    check("cont_quiet_done", bus.done0 | bus.done1, 0);
    check("cont_quiet_psel", bus.PSEL1 | bus.PSEL2, 0);
    check("cont_rdata0", bus.rdata0, 8'h42);
    check("cont_err0", bus.err0, 0);
    check("cont_err1", bus.err1, 0);
    bus.PREADY = 1'b0;
  endtask

  task automatic reset_in_access();
    logic reached;
    logic got_done;
    reached        = 1'b0;
    got_done       = 1'b0;
    bus.req0       = 1'b1;
    bus.req_write0 = 1'b0;
    bus.req_addr0  = 9'h033;
    bus.PREADY     = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      @(negedge clk);
      if (bus.PENABLE) reached = 1'b1;
    end
    check("rst_reached_access", reached, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst_access");
    bus.req1       = 1'b1;
    bus.req_write1 = 1'b0;
    bus.req_addr1  = 9'h133;
    rst            = 1'b0;
    @(negedge clk);
    check("rst_no_done0", bus.done0, 0);
    check("rst_first_psel1", bus.PSEL1, 1);
    check("rst_first_psel2", bus.PSEL2, 0);
    check("rst_first_paddr", bus.PADDR, 9'h033);
    // Dropping req mid-transfer must not cancel it.
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'hC7;
    for (int c = 0; c < 10 && !got_done; c++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        got_done = 1'b1;
        check("rst_after_done0", bus.done0, 1);
        check("rst_after_rdata0", bus.rdata0, 8'hC7);
      end
    end
    check("rst_after_done_seen", got_done, 1);
    bus.PREADY = 1'b0;
  endtask

  initial begin
    //                id    wr    addr    wdata  waits  prdata slverr psel2 cyc   err   rdata
    vecs[0] = '{1'b0, 1'b0, 9'h005, 8'h11, 8'd0,   8'hA5, 1'b0, 1'b0, 4'd2, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 9'h10F, 8'h3C, 8'd3,   8'h77, 1'b0, 1'b1, 4'd5, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 9'h1F0, 8'h22, 8'd1,   8'h5A, 1'b1, 1'b1, 4'd3, 1'b1, 8'h5A};
    vecs[3] = '{1'b0, 1'b0, 9'h022, 8'h33, 8'd255, 8'hEE, 1'b0, 1'b0, 4'd5, 1'b1, 8'h5A};
    vecs[4] = '{1'b1, 1'b0, 9'h0C3, 8'h44, 8'd2,   8'h81, 1'b0, 1'b0, 4'd4, 1'b0, 8'h81};
    vecs[5] = '{1'b0, 1'b1, 9'h1AA, 8'h99, 8'd0,   8'h66, 1'b0, 1'b1, 4'd2, 1'b0, 8'h5A};

    idle_inputs();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i]);
    end

    contention();
    reset_in_access();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum number of ACCESS cycles with PREADY low before the transfer is aborted; legal range 1..255.
REQ-002 PCLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 PRESET  in  1  synchronous, active-high reset.
REQ-004 req0, req1  in  1 each  requester transfer request; held high with fields stable until the matching done.
REQ-005 req_write0, req_write1  in  1 each  1 = write, 0 = read.
REQ-006 req_addr0, req_addr1  in  9 each  transfer address; bit 8 selects the slave (0 = PSEL1, 1 = PSEL2).
REQ-007 req_wdata0, req_wdata1  in  8 each  write data.
REQ-008 done0, done1  out  1 each  one-cycle completion pulse to the requester.
REQ-009 rdata0, rdata1  out  8 each  read data returned to the requester.
REQ-010 err0, err1  out  1 each  completion status; valid while done is high and held afterwards.
REQ-011 PSEL1, PSEL2, PENABLE, PWRITE  out  1 each  APB control outputs.
REQ-012 PADDR  out  9  APB address.
REQ-013 PWDATA  out  8  APB write data.
REQ-014 PREADY, PSLVERR  in  1 each  already muxed by the slave select.
REQ-015 PRDATA  in  8  already muxed by the slave select.

Function
REQ-016 Registered FSM states: IDLE, SETUP, ACCESS; all APB outputs are registered.
REQ-017 IDLE: an eligible request moves the FSM to SETUP on the next edge.
- At that edge, latch the winner's address, write flag and write data into PADDR, PWRITE and PWDATA.
- At that edge, drive PSEL1 or PSEL2 per PADDR[8]; PENABLE = 0.
REQ-018 SETUP always lasts exactly 1 cycle, then moves to ACCESS with PENABLE = 1 and PSEL unchanged.
REQ-019 ACCESS with PREADY = 1 at the edge: the transfer completes.
- FSM moves to IDLE; PSEL and PENABLE go to 0.
- The granted requester's done = 1 for exactly the next cycle.
- err = PSLVERR.
REQ-020 On completion of a read, rdata of the granted requester captures PRDATA; a write leaves rdata unchanged.
REQ-021 The wait counter resets to 0 on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
REQ-022 When the wait counter reaches WAIT_MAX with PREADY still 0, the transfer aborts.
- FSM moves to IDLE; PSEL and PENABLE go to 0.
- done pulses for 1 cycle with err = 1; rdata is unchanged.
REQ-023 Arbitration is round-robin using a last_gnt register.
- Both requesters eligible: grant the one that is not last_gnt.
- One requester eligible: grant it.
- last_gnt updates on every grant.
REQ-024 A requester whose done is high in the current cycle is not eligible in that cycle, which prevents a duplicate transfer from a held req.
REQ-025 Minimum transfer length is 3 cycles edge-to-edge (IDLE, SETUP, ACCESS with PREADY = 1); back-to-back grants leave exactly one IDLE cycle between transfers.
REQ-026 PADDR, PWRITE and PWDATA hold their values from SETUP through the end of ACCESS; requester inputs are ignored outside IDLE.
REQ-027 PSEL1 and PSEL2 are never high simultaneously; PENABLE is high only in ACCESS.
REQ-028 A req that drops while its transfer is in progress does not cancel the transfer; done is still issued.

Reset
REQ-029 While PRESET = 1 at an edge:
- FSM = IDLE; wait counter = 0; last_gnt = 1, so requester 0 wins the first tie.
- PSEL1 = PSEL2 = PENABLE = PWRITE = 0; PADDR = 0; PWDATA = 0.
- done0 = done1 = 0; err0 = err1 = 0; rdata0 = rdata1 = 8'h00.
REQ-030 A reset asserted mid-transfer (in SETUP or ACCESS) drops PSEL and PENABLE at that edge and issues no done for the aborted transfer.

Verification
REQ-031 Single read:
- Stimulus: req0, addr 9'h005, slave returns PREADY = 1 in the first ACCESS cycle with PRDATA = 8'hA5.
- Required: PSEL1 high for 2 cycles; done0 pulses one cycle later; rdata0 = 8'hA5; err0 = 0.
REQ-032 Write with wait states:
- Stimulus: req1, addr 9'h10F, wdata 8'h3C, PREADY low for 3 cycles.
- Required: PSEL2 high, PWRITE = 1, PWDATA = 8'h3C for 5 cycles; done1 pulses; err1 = 0.
REQ-033 Contention:
- Stimulus: req0 and req1 both asserted and held high from reset.
- Required: grant order 0,1,0,1; each done pulses once per transfer; one IDLE cycle between transfers; never two PSELs high.
REQ-034 Timeout:
- Stimulus: WAIT_MAX = 4, PREADY held 0.
- Required: abort after 4 ACCESS cycles; done0 pulses with err0 = 1; rdata0 unchanged.
REQ-035 Slave error:
- Stimulus: PSLVERR = 1 together with PREADY = 1 on a read.
- Required: err = 1, rdata = PRDATA, done pulses.
REQ-036 Reset in ACCESS:
- Stimulus: PRESET asserted during ACCESS.
- Required: all outputs 0 at the next edge; no done; the first grant after reset goes to requester 0.
